// File: rtl/instr_loader_pkg.sv
// Shared constants and state encoding for the UART instruction byte loader.
// Words are assembled from BYTES_PER_WORD bytes, most significant byte first.
package instr_loader_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = DATA_WIDTH / BYTE_W;

    typedef enum logic [1:0] {
        GET_COUNT,
        LOAD,
        DONE
    } loader_state_t;

    // The byte counter wraps modulo BYTES_PER_WORD, so its top value marks a word boundary.
    function automatic logic is_last_byte(input logic [1:0] cnt);
        return cnt == 2'(BYTES_PER_WORD - 1);
    endfunction

endpackage

// File: rtl/byte_shift_reg.sv
// Byte-wide shift register that assembles a word MSB-first and strobes
// word_done on the edge that accepts the final byte of each word.
module byte_shift_reg
    import instr_loader_pkg::*;
#(
    parameter int BYTE_WIDTH = BYTE_W,
    parameter int WORD_WIDTH = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [BYTE_WIDTH-1:0] data_in,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  word_done
);

    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;

    always_comb begin
        data_d     = data_q;
        byte_cnt_d = byte_cnt_q;
        word_done  = 1'b0;
        if (en) begin
            data_d     = {data_q[WORD_WIDTH-BYTE_WIDTH-1:0], data_in};
            byte_cnt_d = byte_cnt_q + 2'd1;
            word_done  = is_last_byte(byte_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            byte_cnt_q <= '0;
        end else begin
            data_q     <= data_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: rtl/instr_byte_loader.sv
// UART-side instruction loader: a count byte followed by 32-bit words,
// each completed word stored into a small instruction memory for the core.
module instr_byte_loader
    import instr_loader_pkg::*;
#(
    parameter int INPUT_BYTE     = 8,
    parameter int N_INSTRUCTIONS = 8,
    parameter int ADDR_W         = $clog2(N_INSTRUCTIONS)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  w_en,
    input  logic [INPUT_BYTE-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  instr_valid,
    output logic [7:0]            instr_count,
    output logic                  load_done,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam logic [7:0] MEM_DEPTH = 8'(N_INSTRUCTIONS);

    loader_state_t         state_q, state_d;
    logic [7:0]            target_q, target_d;
    logic [7:0]            word_cnt_q, word_cnt_d;
    logic [7:0]            instr_count_q, instr_count_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  load_done_q, load_done_d;

    logic                  shift_en;
    logic                  word_done;
    logic [DATA_WIDTH-1:0] shift_data;

    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem [N_INSTRUCTIONS];

    byte_shift_reg #(
        .BYTE_WIDTH(INPUT_BYTE),
        .WORD_WIDTH(DATA_WIDTH)
    ) u_shift (
        .clk      (clk),
        .rst      (arst_n),
        .en       (shift_en),
        .data_in  (data_in),
        .data_out (shift_data),
        .word_done(word_done)
    );

    // The word counter keeps running past the memory depth so an oversized
    // count still terminates; extra words are simply not stored.
    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        word_cnt_d    = word_cnt_q;
        instr_count_d = instr_count_q;
        instr_valid_d = 1'b0;
        load_done_d   = load_done_q;
        shift_en      = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = word_cnt_q[ADDR_W-1:0];
        mem_wdata     = {shift_data[DATA_WIDTH-INPUT_BYTE-1:0], data_in};

        case (state_q)
            GET_COUNT: begin
                if (w_en) begin
                    target_d = data_in;
                    if (data_in == '0) begin
                        state_d     = DONE;
                        load_done_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (w_en) begin
                    shift_en = 1'b1;
                    if (word_done) begin
                        instr_valid_d = 1'b1;
                        word_cnt_d    = word_cnt_q + 8'd1;
                        if (word_cnt_q < MEM_DEPTH) begin
                            mem_we        = 1'b1;
                            instr_count_d = instr_count_q + 8'd1;
                        end
                        if (word_cnt_q + 8'd1 == target_q) begin
                            state_d     = DONE;
                            load_done_d = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = GET_COUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst_n) begin
            state_q       <= GET_COUNT;
            target_q      <= '0;
            word_cnt_q    <= '0;
            instr_count_q <= '0;
            instr_valid_q <= 1'b0;
            load_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            word_cnt_q    <= word_cnt_d;
            instr_count_q <= instr_count_d;
            instr_valid_q <= instr_valid_d;
            load_done_q   <= load_done_d;
        end
    end

    // Memory is deliberately not cleared by reset; reset only blocks a write.
    always_ff @(posedge clk) begin
        if (mem_we && !arst_n) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_data     = mem[rd_addr];
    assign data_out    = shift_data;
    assign instr_valid = instr_valid_q;
    assign instr_count = instr_count_q;
    assign load_done   = load_done_q;

endmodule

// File: tb/tb_instr_byte_loader.sv
// Self-checking bench for instr_byte_loader: a byte-stream model compared every
// cycle, plus literal expectations from hand-worked load sequences.
module tb_instr_byte_loader;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        w_en;
    logic [7:0]  data_in;
    logic [31:0] data_out;
    logic        instr_valid;
    logic [7:0]  instr_count;
    logic        load_done;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;

    always #5 clk = ~clk;

    instr_byte_loader #(
        .INPUT_BYTE(8),
        .N_INSTRUCTIONS(8)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .w_en       (w_en),
        .data_in    (data_in),
        .data_out   (data_out),
        .instr_valid(instr_valid),
        .instr_count(instr_count),
        .load_done  (load_done),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int valid_pulses = 0;

    // Model: payload bytes since reset, a word every 4 bytes.
    bit          mdl_ready = 1'b0;
    bit          mdl_have_count;
    int          mdl_target;
    bit          mdl_done;
    int          mdl_words;
    bit          mdl_valid;
    logic [7:0]  stream [$];
    logic [31:0] mdl_mem [8];
    bit          mdl_written [8];

    function automatic logic [31:0] tail_word();
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 4; i++) begin
            int idx;
            idx = stream.size() - 4 + i;
            r = (idx >= 0) ? {r[23:0], stream[idx]} : {r[23:0], 8'h00};
        end
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin
        mdl_valid = 1'b0;
        if (arst_n) begin
            mdl_ready      = 1'b1;
            mdl_have_count = 1'b0;
            mdl_target     = 0;
            mdl_done       = 1'b0;
            mdl_words      = 0;
            stream.delete();
        end else if (mdl_ready && w_en) begin
            if (!mdl_have_count) begin
                mdl_have_count = 1'b1;
                mdl_target     = int'(data_in);
                if (mdl_target == 0) mdl_done = 1'b1;
            end else if (!mdl_done) begin
                stream.push_back(data_in);
                if (stream.size() % 4 == 0) begin
                    if (mdl_words < 8) begin
                        mdl_mem[mdl_words]     = tail_word();
                        mdl_written[mdl_words] = 1'b1;
                    end
                    mdl_words++;
                    mdl_valid = 1'b1;
                    if (mdl_words == mdl_target) mdl_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_ready) begin
            check_output("cyc_data_out", data_out, tail_word());
            check_output("cyc_instr_valid", {31'h0, instr_valid}, {31'h0, mdl_valid});
            check_output("cyc_instr_count", {24'h0, instr_count}, (mdl_words > 8) ? 32'd8 : 32'(mdl_words));
            check_output("cyc_load_done", {31'h0, load_done}, {31'h0, mdl_done});
            if (mdl_written[rd_addr]) check_output("cyc_rd_data", rd_data, mdl_mem[rd_addr]);
        end
        if (instr_valid === 1'b1) valid_pulses++;
    end

    task automatic apply_stimulus(input logic we, input logic [7:0] d);
        w_en    = we;
        data_in = d;
        @(posedge clk);
        #1;
        w_en    = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] d);
        apply_stimulus(1'b1, d);
        apply_stimulus(1'b0, 8'h00);
        apply_stimulus(1'b0, 8'h00);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_gap(w[31:24]);
        send_gap(w[23:16]);
        send_gap(w[15:8]);
        send_gap(w[7:0]);
    endtask

    task automatic do_reset();
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        arst_n = 1'b0;
    endtask

    task automatic check_mem(input string name, input logic [2:0] a, input logic [31:0] expected);
        rd_addr = a;
        #1;
        check_output(name, rd_data, expected);
    endtask

    initial begin
        int base;
        logic [31:0] words3 [3];
        foreach (mdl_written[i]) mdl_written[i] = 1'b0;
        arst_n  = 1'b1;
        w_en    = 1'b0;
        data_in = 8'h00;
        rd_addr = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b0;

        check_output("reset_data_out", data_out, 32'h0);
        check_output("reset_instr_count", {24'h0, instr_count}, 32'h0);
        check_output("reset_load_done", {31'h0, load_done}, 32'h0);
        check_output("reset_instr_valid", {31'h0, instr_valid}, 32'h0);

        // Single word
        base = valid_pulses;
        send_gap(8'h01);
        send_word(32'h00000513);
        check_output("one_data_out", data_out, 32'h00000513);
        check_output("one_instr_count", {24'h0, instr_count}, 32'd1);
        check_output("one_load_done", {31'h0, load_done}, 32'd1);
        check_output("one_pulses", 32'(valid_pulses - base), 32'd1);
        check_mem("one_mem0", 3'd0, 32'h00000513);

        // Three words
        do_reset();
        base = valid_pulses;
        words3[0] = 32'h00100593;
        words3[1] = 32'h00A00613;
        words3[2] = 32'h00060C63;
        send_gap(8'h03);
        send_word(words3[0]);
        send_word(words3[1]);
        check_output("three_not_done", {31'h0, load_done}, 32'd0);
        send_word(words3[2]);
        check_output("three_done", {31'h0, load_done}, 32'd1);
        check_output("three_pulses", 32'(valid_pulses - base), 32'd3);
        for (int i = 0; i < 3; i++) check_mem("three_mem", 3'(i), words3[i]);

        // Ten announced, eight stored
        do_reset();
        base = valid_pulses;
        send_gap(8'h0A);
        for (int i = 0; i < 9; i++) send_word(32'hA0000000 | 32'(i));
        check_output("ten_not_done", {31'h0, load_done}, 32'd0);
        check_output("ten_sat_count", {24'h0, instr_count}, 32'd8);
        send_word(32'hA0000009);
        check_output("ten_done", {31'h0, load_done}, 32'd1);
        check_output("ten_count", {24'h0, instr_count}, 32'd8);
        check_output("ten_pulses", 32'(valid_pulses - base), 32'd10);
        check_mem("ten_mem7", 3'd7, 32'hA0000007);
        check_mem("ten_mem0", 3'd0, 32'hA0000000);

        // Reset mid-word
        do_reset();
        send_gap(8'h01);
        send_gap(8'hFE);
        send_gap(8'hDF);
        do_reset();
        check_output("midrst_data_out", data_out, 32'h0);
        send_gap(8'h01);
        send_word(32'hFFF60613);
        check_output("midrst_word", data_out, 32'hFFF60613);
        check_mem("midrst_mem0", 3'd0, 32'hFFF60613);

        // Back-to-back bytes
        do_reset();
        apply_stimulus(1'b1, 8'h02);
        apply_stimulus(1'b1, 8'h00);
        apply_stimulus(1'b1, 8'hB5);
        apply_stimulus(1'b1, 8'h02);
        apply_stimulus(1'b1, 8'hB3);
        check_output("b2b_data_out", data_out, 32'h00B502B3);
        check_output("b2b_valid", {31'h0, instr_valid}, 32'd1);
        check_output("b2b_not_done", {31'h0, load_done}, 32'd0);
        send_word(32'h11223344);
        check_output("b2b_done", {31'h0, load_done}, 32'd1);

        // Bytes after done are ignored
        base = valid_pulses;
        apply_stimulus(1'b1, 8'h55);
        apply_stimulus(1'b1, 8'h66);
        apply_stimulus(1'b1, 8'h77);
        apply_stimulus(1'b1, 8'h88);
        apply_stimulus(1'b0, 8'h00);
        check_output("post_data_out", data_out, 32'h11223344);
        check_output("post_count", {24'h0, instr_count}, 32'd2);
        check_output("post_pulses", 32'(valid_pulses - base), 32'd0);
        check_mem("post_mem0", 3'd0, 32'h00B502B3);
        check_mem("post_mem1", 3'd1, 32'h11223344);

        // Reset wins over a simultaneous zero count, then a real zero count
        arst_n = 1'b1;
        apply_stimulus(1'b1, 8'h00);
        arst_n = 1'b0;
        check_output("rstwin_load_done", {31'h0, load_done}, 32'd0);
        base = valid_pulses;
        send_gap(8'h00);
        check_output("zero_load_done", {31'h0, load_done}, 32'd1);
        check_output("zero_pulses", 32'(valid_pulses - base), 32'd0);
        check_output("zero_count", {24'h0, instr_count}, 32'd0);
        send_gap(8'h12);
        check_output("zero_data_out", data_out, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_byte_loader.md
Name: instr_byte_loader

Overview:
- Byte-serial instruction loader for the Fibonacci microprocessor's UART front end.
- First accepted byte is an instruction count. Every following group of 4 bytes is shifted MSB-first into a 32-bit word.
- Each completed word is written into a small internal instruction memory that the core can read back.

Parameters:
- DATA_WIDTH, 32, assembled word width (fixed at 4 bytes).
- INPUT_BYTE, 8, width of data_in.
- N_INSTRUCTIONS, 8, depth of instruction memory; maximum number of words stored.

Ports:
- clk  in  1  rising-edge clock.
- arst_n  in  1  reset, synchronous, active-high (1 = reset), sampled on posedge clk.
- w_en  in  1  byte strobe; each cycle high at a posedge accepts data_in.
- data_in  in  8  incoming byte.
- data_out  out  32  current shift-register contents (assembled instruction).
- instr_valid  out  1  one-cycle pulse: data_out holds a complete word.
- instr_count  out  8  number of words stored so far (saturates at N_INSTRUCTIONS).
- load_done  out  1  high once all announced instructions are received; sticky until reset.
- rd_addr  in  $clog2(N_INSTRUCTIONS)  memory read address.
- rd_data  out  32  memory read data, combinational from rd_addr.

Behaviour:
- Reset (arst_n=1 at posedge): state=GET_COUNT, data_out=0, byte_cnt=0, target=0, instr_count=0, instr_valid=0, load_done=0. Memory contents are not cleared; rd_data of unwritten entries is undefined.
- FSM states: GET_COUNT, LOAD, DONE.
- GET_COUNT, w_en=1: target<=data_in.
  - data_in=0: go to DONE, load_done<=1 next edge.
  - otherwise: go to LOAD.
  - The count byte is not shifted into data_out.
- LOAD, w_en=1:
  - data_out<={data_out[23:0],data_in}; byte_cnt<=byte_cnt+1 (mod 4).
  - The first byte of a word ends up in data_out[31:24].
- LOAD, 4th byte of a word (byte_cnt==3 with w_en):
  - Same edge: shift completes; instr_valid<=1 for exactly one cycle.
  - If word index < N_INSTRUCTIONS: mem[index]<={data_out[23:0],data_in} and instr_count increments. Otherwise the word is dropped and instr_count holds.
  - When the number of words received equals target: go to DONE, load_done<=1.
- Word counter (words received, 8 bits) is separate from instr_count so that target > N_INSTRUCTIONS still terminates.
- DONE: w_en ignored; data_out holds the last word.
- Latency: data_out and instr_valid are visible in the cycle after the accepting edge.
- w_en held high N cycles accepts N bytes, one per edge. There is no back-pressure.
- w_en=0: all registers hold.
- Reset mid-word: partial bytes are discarded; the next accepted byte is treated as a count.
- Simultaneous reset and w_en: reset wins.

Decomposition:
- Package instr_loader_pkg holds:
  - DATA_WIDTH and BYTE_W constants.
  - BYTES_PER_WORD=4.
  - typedef enum logic [1:0] {GET_COUNT, LOAD, DONE} loader_state_t.
- One sub-module, byte_shift_reg: parameterised 8-to-32 shift register with en, data_in, data_out and a word_done strobe from a 2-bit byte counter.
- FSM, counters and memory live in instr_byte_loader.

Test Plan:
- Reset, then count byte 0x01, then bytes 00,00,05,13 each as a 1-cycle w_en pulse with idle gaps.
  - data_out=0x00000513 and instr_valid pulses once.
  - instr_count=1, load_done=1, rd_addr=0 gives rd_data=0x00000513.
- Count 0x03, words 0x00100593, 0x00A00613, 0x00060C63.
  - Three instr_valid pulses; rd_data[0..2] match in order; load_done rises after the last byte.
- Count 0x0A (10) with N_INSTRUCTIONS=8.
  - 10 instr_valid pulses; instr_count saturates at 8; mem[7] is the 8th word; load_done after the 10th word.
- Reset asserted after 2 bytes (FE,DF).
  - data_out=0.
  - Next byte 0x01 is taken as count; then FF,F6,06,13 gives data_out=0xFFF60613.
- w_en held high 5 cycles with data_in=0x02 then 4 bytes 00,B5,02,B3 on consecutive edges.
  - Word 0x00B502B3 in data_out one cycle after the 5th edge.
- After load_done, further w_en bytes: data_out, instr_count and memory unchanged. Count 0x00 gives load_done=1 with no instr_valid.
